// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the register-bank read path.
// Optional MUX_PARITY_EN adds a registered parity output to reg_bank_mux.
package reg_bank_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int SEL_W     = 3;
  localparam int NUM_REGS  = 8;

  typedef logic [WIDTH_DEF-1:0] word_t;
endpackage

// File: rtl/reg_bank_mux_mux8_comb.sv
// Purely combinational 8:1 word selector.
// Unknown select codes resolve to zero so X never reaches the output.
module mux8_comb
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [NUM_REGS-1:0][WIDTH-1:0] d_i,
  input  logic [SEL_W-1:0]               sel_i,
  output logic [WIDTH-1:0]               y_o
);

  always_comb begin
    y_o = '0;
    case (sel_i)
      3'd0:    y_o = d_i[0];
      3'd1:    y_o = d_i[1];
      3'd2:    y_o = d_i[2];
      3'd3:    y_o = d_i[3];
      3'd4:    y_o = d_i[4];
      3'd5:    y_o = d_i[5];
      3'd6:    y_o = d_i[6];
      3'd7:    y_o = d_i[7];
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/reg_bank_mux.sv
// Registered 8:1 read-data selector for the register bank.
// Define MUX_PARITY_EN to add the registered out_parity output.
module reg_bank_mux
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] input0,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [WIDTH-1:0] input3,
  input  logic [WIDTH-1:0] input4,
  input  logic [WIDTH-1:0] input5,
  input  logic [WIDTH-1:0] input6,
  input  logic [WIDTH-1:0] input7,
  input  logic [SEL_W-1:0] control,
  output logic [WIDTH-1:0] output0,
  output logic             out_valid
`ifdef MUX_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  logic [NUM_REGS-1:0][WIDTH-1:0] words;
  logic [WIDTH-1:0]               data_d;
  logic [WIDTH-1:0]               data_q;
  logic                           valid_q;

  assign words = {input7, input6, input5, input4,
                  input3, input2, input1, input0};

  mux8_comb #(
    .WIDTH (WIDTH)
  ) u_mux (
    .d_i   (words),
    .sel_i (control),
    .y_o   (data_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= 1'b1;
    end
  end

  assign output0   = data_q;
  assign out_valid = valid_q;

`ifdef MUX_PARITY_EN
  logic par_d;
  logic par_q;

  assign par_d = ^data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign out_parity = par_q;
`endif

endmodule

// File: tb/tb_reg_bank_mux.sv
// Scoreboard bench for reg_bank_mux: driver pushes expected words,
// monitor pops and compares one cycle later.
module tb_reg_bank_mux;
  import reg_bank_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] din [8];
  logic [15:0] stage [8];
  logic [2:0]  control;
  logic [15:0] output0;
  logic        out_valid;
`ifdef MUX_PARITY_EN
  logic        out_parity;
`endif

  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q [$];

  reg_bank_mux dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .input0    (din[0]),
    .input1    (din[1]),
    .input2    (din[2]),
    .input3    (din[3]),
    .input4    (din[4]),
    .input5    (din[5]),
    .input6    (din[6]),
    .input7    (din[7]),
    .control   (control),
    .output0   (output0),
    .out_valid (out_valid)
`ifdef MUX_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  // Reference: parity is odd-count of ones in the selected word.
  function automatic logic [16:0] model(input logic [2:0] c);
    logic [15:0] w;
    w = stage[c];
    return {1'($countones(w) % 2), w};
  endfunction

  task automatic step(input logic [2:0] c);
    @(negedge clk);
    control = c;
    for (int i = 0; i < 8; i++) din[i] = stage[i];
    exp_q.push_back(model(c));
  endtask

  always begin
    @(posedge clk);
    #1;
    if (rst_n && exp_q.size() > 0) begin
      logic [16:0] e;
      e = exp_q.pop_front();
      chk("data", 32'(output0), 32'(e[15:0]));
      chk("valid", 32'(out_valid), 32'd1);
`ifdef MUX_PARITY_EN
      chk("parity", 32'(out_parity), 32'(e[16]));
`endif
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] tbl [8];
    logic [2:0]  seq [7];
    tbl = '{16'h5555, 16'h0001, 16'h0000, 16'h8000,
            16'hFFFF, 16'h8843, 16'h55FF, 16'h5710};
    seq = '{3'd2, 3'd0, 3'd7, 3'd5, 3'd1, 3'd3, 3'd4};

    rst_n   = 1'b0;
    control = 3'd0;
    for (int i = 0; i < 8; i++) begin
      stage[i] = tbl[i];
      din[i]   = tbl[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(output0), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_data", 32'(output0), 32'h5555);

    foreach (seq[k]) step(seq[k]);
    drain();

    step(3'd1);
    stage[0] = 16'h0000;
    step(3'd0);
    drain();

    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < 8; i++)
        if ($urandom_range(0, 3) == 0) stage[i] = 16'($urandom);
      step(3'($urandom_range(0, 7)));
    end
    drain();

    stage[4] = 16'hFFFF;
    step(3'd4);
    drain();
    chk("pre_rst", 32'(output0), 32'hFFFF);
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", 32'(output0), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
`ifdef MUX_PARITY_EN
    chk("async_rst_par", 32'(out_parity), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 30; n++) begin
      stage[$urandom_range(0, 7)] = 16'($urandom);
      step(3'($urandom_range(0, 7)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
